// File: rtl/rf_write_sched_pkg.sv
// rf_sched_pkg: shared FSM state type and register-file constants for rf_write_sched.
package rf_sched_pkg;
    typedef enum logic {INIT, RUN} rf_sched_state_t;
    localparam int NUM_REGS = 16;
    localparam int PC_REG   = 15;
endpackage

// File: rtl/rf_write_sched_rr_arbiter.sv
// rr_arbiter: combinational N-way round-robin grant starting at ptr, with next-pointer.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx,
    output logic          any,
    output logic [PW-1:0] ptr_nxt
);
    logic [PW-1:0] j;
    always_comb begin
        gnt     = '0;
        idx     = ptr;
        any     = 1'b0;
        ptr_nxt = ptr;
        j       = '0;
        // walk from farthest to nearest so the requester closest to ptr wins
        for (int k = N - 1; k >= 0; k--) begin
            j = PW'((int'(ptr) + k) % N);
            if (req[j]) begin
                gnt     = '0;
                gnt[j]  = 1'b1;
                idx     = j;
                any     = 1'b1;
                ptr_nxt = PW'((int'(j) + 1) % N);
            end
        end
    end
endmodule

// File: rtl/rf_write_sched.sv
// rf_write_sched: zero-init sweep, round-robin writeback onto the register file port, busy scoreboard.
// Define RF_WRITE_SCHED_PC_PROTECT_EN to drop RUN-state writes to the PC register and pulse wr_err.
module rf_write_sched
    import rf_sched_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int DW   = 32,
    parameter int AW   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
    input  logic                 rsv_valid,
    input  logic [AW-1:0]        rsv_addr,
    output logic [2**AW-1:0]     busy_vec,
    output logic                 rf_wr_en,
    output logic [AW-1:0]        rf_write_addr,
    output logic [DW-1:0]        rf_write_data,
    output logic                 init_done,
    output logic                 wr_err
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    rf_sched_state_t state, state_nxt;
    logic [AW-1:0]     cnt;
    logic [PW-1:0]     ptr, ptr_nxt, idx;
    logic              any, run;
    logic [AW-1:0]     sel_addr, addr_d;
    logic [DW-1:0]     sel_data, data_d;
    logic              wr_en_d, err_d;
    logic [2**AW-1:0]  busy_nxt;

    assign run      = state == RUN;
    assign sel_addr = req_addr[idx*AW +: AW];
    assign sel_data = req_data[idx*DW +: DW];

    rr_arbiter #(.N(NREQ), .PW(PW)) u_arb (
        .req     (req_valid & {NREQ{run}}),
        .ptr     (ptr),
        .gnt     (req_ready),
        .idx     (idx),
        .any     (any),
        .ptr_nxt (ptr_nxt)
    );

    always_comb begin
        state_nxt = state;
        wr_en_d   = 1'b0;
        err_d     = 1'b0;
        addr_d    = rf_write_addr;
        data_d    = rf_write_data;
        if (!run) begin
            wr_en_d   = 1'b1;
            addr_d    = cnt;
            data_d    = '0;
            state_nxt = (cnt == AW'(PC_REG)) ? RUN : INIT;
        end else if (any) begin
            wr_en_d = 1'b1;
            addr_d  = sel_addr;
            data_d  = sel_data;
`ifdef RF_WRITE_SCHED_PC_PROTECT_EN
            // accepted but never reaches the file; the address is still registered so the busy bit clears
            if (sel_addr == AW'(PC_REG)) begin
                wr_en_d = 1'b0;
                err_d   = 1'b1;
            end
`endif
        end
    end

    always_comb begin
        busy_nxt = busy_vec;
        if (rf_wr_en || wr_err) busy_nxt[rf_write_addr] = 1'b0;
        if (run && rsv_valid) busy_nxt[rsv_addr] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= INIT;
            cnt           <= '0;
            ptr           <= '0;
            busy_vec      <= '0;
            rf_wr_en      <= 1'b0;
            rf_write_addr <= '0;
            rf_write_data <= '0;
            init_done     <= 1'b0;
            wr_err        <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= run ? cnt : cnt + 1'b1;
            ptr           <= ptr_nxt;
            busy_vec      <= busy_nxt;
            rf_wr_en      <= wr_en_d;
            rf_write_addr <= addr_d;
            rf_write_data <= data_d;
            init_done     <= state_nxt == RUN;
            wr_err        <= err_d;
        end
    end
endmodule
